// File: rtl/relu_quant_pack_pkg.sv
// Shared parameters, state encoding and helpers for the ReLU output stage.
// BW_RELU is derived here so the ReLU block and this block agree on lane width.
package relu_quant_pack_pkg;

    localparam int unsigned BITWIDTH      = 8;
    localparam int unsigned OUT_CHANNEL   = 4;
    localparam int unsigned GROUP_CHANNEL = 16;
    localparam int unsigned BW_RELU       = 2 * BITWIDTH + 4 + $clog2(GROUP_CHANNEL) + 10;
    localparam int unsigned BW_FL         = 5;
    localparam int unsigned PACK          = 4;
    localparam int unsigned ADDR_W        = 10;
    localparam int unsigned SAT_W         = 16;

    localparam int unsigned PACK_W  = $clog2(PACK);
    localparam int unsigned TUPLE_W = OUT_CHANNEL * BITWIDTH;
    localparam int unsigned IN_W    = OUT_CHANNEL * BW_RELU;
    localparam int unsigned WORD_W  = PACK * TUPLE_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    // Add the per-tuple clip flags to the tile counter, sticking at all-ones.
    function automatic logic [SAT_W-1:0] sat_add(input logic [SAT_W-1:0] cnt,
                                                 input logic [OUT_CHANNEL-1:0] flags);
        logic [SAT_W:0] sum;
        sum = {1'b0, cnt};
        for (int i = 0; i < OUT_CHANNEL; i++) begin
            sum = sum + (SAT_W + 1)'(flags[i]);
        end
        return sum[SAT_W] ? '1 : sum[SAT_W-1:0];
    endfunction

endpackage

// File: rtl/relu_quant_pack_requant_lane.sv
// One lane of requantization: round-half-up arithmetic right shift, then
// saturation to signed BITWIDTH with a clip flag.
module relu_quant_pack_requant_lane
    import relu_quant_pack_pkg::*;
(
    input  logic [BW_RELU-1:0]  x,
    input  logic [BW_FL-1:0]    shift,
    output logic [BITWIDTH-1:0] q_c,
    output logic                sat_c
);

    localparam int unsigned EXT_W = BW_RELU + 1;
    localparam logic signed [EXT_W-1:0] Q_MAX = EXT_W'((1 << (BITWIDTH - 1)) - 1);
    localparam logic signed [EXT_W-1:0] Q_MIN = ~Q_MAX;

    logic signed [EXT_W-1:0] x_ext;
    logic signed [EXT_W-1:0] rnd;
    logic signed [EXT_W-1:0] sum;
    logic signed [EXT_W-1:0] r;

    // One guard bit keeps x + 2^(s-1) from overflowing.
    always_comb begin
        x_ext = $signed({x[BW_RELU-1], x});
        rnd   = '0;
        if (shift != '0) begin
            rnd = EXT_W'(1) << (shift - BW_FL'(1));
        end
        sum   = x_ext + rnd;
        r     = sum >>> shift;
        q_c   = r[BITWIDTH-1:0];
        sat_c = 1'b0;
        if (r > Q_MAX) begin
            q_c   = Q_MAX[BITWIDTH-1:0];
            sat_c = 1'b1;
        end else if (r < Q_MIN) begin
            q_c   = Q_MIN[BITWIDTH-1:0];
            sat_c = 1'b1;
        end
    end

endmodule

// File: rtl/relu_quant_pack.sv
// ReLU output stage: requantizes each accepted tuple and packs PACK tuples
// per output-SRAM word, written to sequential addresses from a tile base.
module relu_quant_pack
    import relu_quant_pack_pkg::*;
(
    input  logic              clk,
    input  logic              srstn,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [BW_FL-1:0]  out_shift,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    input  logic [IN_W-1:0]   in_data,
    output logic              sram_wen,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [WORD_W-1:0] sram_wdata,
    output logic              done,
    output logic [SAT_W-1:0]  sat_cnt
);

    state_t             state;
    logic [ADDR_W-1:0]  addr;
    logic [BW_FL-1:0]   shift_r;
    logic [PACK_W-1:0]  pack_cnt;
    logic [WORD_W-1:0]  pack_buf;

    logic [TUPLE_W-1:0]     tuple_q;
    logic [OUT_CHANNEL-1:0] lane_sat;
    logic [WORD_W-1:0]      word_c;
    logic                   accept_c;
    logic                   word_full_c;

    for (genvar i = 0; i < OUT_CHANNEL; i++) begin : g_lane
        relu_quant_pack_requant_lane u_lane (
            .x     (in_data[(OUT_CHANNEL - 1 - i) * BW_RELU +: BW_RELU]),
            .shift (shift_r),
            .q_c   (tuple_q[(OUT_CHANNEL - 1 - i) * BITWIDTH +: BITWIDTH]),
            .sat_c (lane_sat[i])
        );
    end

    // Unfilled slots of pack_buf are always zero, so a partial word needs no masking.
    always_comb begin
        word_c = pack_buf;
        for (int k = 0; k < PACK; k++) begin
            if (pack_cnt == PACK_W'(k)) begin
                word_c[(PACK - 1 - k) * TUPLE_W +: TUPLE_W] = tuple_q;
            end
        end
        accept_c    = in_valid && in_ready;
        word_full_c = (pack_cnt == PACK_W'(PACK - 1)) || in_last;
    end

    always_ff @(posedge clk) begin
        if (!srstn) begin
            state      <= IDLE;
            addr       <= '0;
            shift_r    <= '0;
            pack_cnt   <= '0;
            pack_buf   <= '0;
            in_ready   <= 1'b0;
            sram_wen   <= 1'b0;
            sram_addr  <= '0;
            sram_wdata <= '0;
            done       <= 1'b0;
            sat_cnt    <= '0;
        end else begin
            sram_wen <= 1'b0;
            done     <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        addr     <= base_addr;
                        shift_r  <= out_shift;
                        pack_cnt <= '0;
                        pack_buf <= '0;
                        sat_cnt  <= '0;
                        in_ready <= 1'b1;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    if (accept_c) begin
                        sat_cnt <= sat_add(sat_cnt, lane_sat);
                        if (word_full_c) begin
                            sram_wen   <= 1'b1;
                            sram_addr  <= addr;
                            sram_wdata <= word_c;
                            addr       <= addr + ADDR_W'(1);
                            pack_buf   <= '0;
                            pack_cnt   <= '0;
                        end else begin
                            pack_buf <= word_c;
                            pack_cnt <= pack_cnt + PACK_W'(1);
                        end
                        if (in_last) begin
                            in_ready <= 1'b0;
                            state    <= FLUSH;
                        end
                    end
                end
                // The last word was issued on the in_last handshake; only done remains.
                FLUSH: begin
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: begin
                    in_ready <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_relu_quant_pack.sv
// Randomized self-checking bench for relu_quant_pack against an arithmetic
// reference of requantization, packing, addressing and handshake timing.
module tb_relu_quant_pack;
    import relu_quant_pack_pkg::*;

    logic              clk = 1'b0;
    logic              srstn;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [BW_FL-1:0]  out_shift;
    logic              in_valid;
    logic              in_ready;
    logic              in_last;
    logic [IN_W-1:0]   in_data;
    logic              sram_wen;
    logic [ADDR_W-1:0] sram_addr;
    logic [WORD_W-1:0] sram_wdata;
    logic              done;
    logic [SAT_W-1:0]  sat_cnt;

    relu_quant_pack dut (
        .clk        (clk),
        .srstn      (srstn),
        .start      (start),
        .base_addr  (base_addr),
        .out_shift  (out_shift),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_last    (in_last),
        .in_data    (in_data),
        .sram_wen   (sram_wen),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .done       (done),
        .sat_cnt    (sat_cnt)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    logic [ADDR_W-1:0] wr_addr_q[$];
    logic [WORD_W-1:0] wr_data_q[$];
    int unsigned       wr_cyc_q[$];
    int unsigned       done_cyc_q[$];

    logic [ADDR_W-1:0] exp_addr_q[$];
    logic [WORD_W-1:0] exp_data_q[$];
    int unsigned       exp_cyc_q[$];
    int unsigned       exp_sat;

    logic [IN_W-1:0] tq[$];

    always @(negedge clk) begin
        if (sram_wen) begin
            wr_addr_q.push_back(sram_addr);
            wr_data_q.push_back(sram_wdata);
            wr_cyc_q.push_back(cyc);
        end
        if (done) done_cyc_q.push_back(cyc);
    end

    task automatic check(input string tag, input logic [WORD_W-1:0] act, input logic [WORD_W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Round half up then floor-divide by 2^s, using plain integer arithmetic.
    function automatic longint ref_round(input longint x, input int s);
        longint d, num, q;
        if (s == 0) return x;
        d   = longint'(1) <<< s;
        num = x + d / 2;
        q   = num / d;
        if ((num % d) != 0 && num < 0) q = q - 1;
        return q;
    endfunction

    function automatic logic [IN_W-1:0] mk_tuple(input longint a, input longint b,
                                                 input longint c, input longint d);
        return {BW_RELU'(a), BW_RELU'(b), BW_RELU'(c), BW_RELU'(d)};
    endfunction

    function automatic longint rand_lane(input int s);
        logic [BW_RELU-1:0] t;
        longint span;
        if ($urandom_range(0, 7) == 0) begin
            t = BW_RELU'({$urandom, $urandom});
            return longint'($signed(t));
        end
        span = longint'(300) <<< (s > 20 ? 20 : s);
        return longint'($urandom_range(0, 32'(2 * span))) - span;
    endfunction

    task automatic fill_random(input int n, input int s);
        tq.delete();
        repeat (n) tq.push_back(mk_tuple(rand_lane(s), rand_lane(s), rand_lane(s), rand_lane(s)));
    endtask

    task automatic clear_queues();
        wr_addr_q.delete(); wr_data_q.delete(); wr_cyc_q.delete(); done_cyc_q.delete();
        exp_addr_q.delete(); exp_data_q.delete(); exp_cyc_q.delete();
        exp_sat = 0;
    endtask

    // mode: 0 back-to-back, 1 alternating valid, 2 random valid.
    task automatic run_tile(input logic [ADDR_W-1:0] base, input int s, input int mode,
                            input bit extra_start);
        int idx, phase, budget, slot, w, n;
        bit v;
        logic [ADDR_W-1:0] addr;
        logic [WORD_W-1:0] word;
        longint x, r, q;
        clear_queues();
        @(negedge clk);
        start = 1'b1; base_addr = base; out_shift = BW_FL'(s);
        @(negedge clk);
        start = 1'b0; base_addr = ADDR_W'($urandom); out_shift = BW_FL'($urandom);
        check("ready_after_start", WORD_W'(in_ready), WORD_W'(1));
        idx = 0; phase = 0; budget = 0; slot = 0; addr = base; word = '0;
        n = tq.size();
        while (idx < n && budget < 1000) begin
            budget++;
            v = (mode == 0) ? 1'b1 : (mode == 1) ? (phase % 2 == 0) : 1'($urandom_range(0, 1));
            phase++;
            in_valid = v;
            in_data  = v ? tq[idx] : IN_W'({$urandom, $urandom, $urandom, $urandom, $urandom});
            in_last  = v ? (idx == n - 1) : 1'($urandom);
            if (extra_start && idx == 1) begin
                start = 1'b1; base_addr = ~base; out_shift = BW_FL'(s + 3);
            end
            if (v && in_ready) begin
                for (int i = 0; i < OUT_CHANNEL; i++) begin
                    x = longint'($signed(tq[idx][(OUT_CHANNEL - 1 - i) * BW_RELU +: BW_RELU]));
                    r = ref_round(x, s);
                    q = r;
                    if (r > 127) begin q = 127; exp_sat++; end
                    else if (r < -128) begin q = -128; exp_sat++; end
                    word[(PACK - 1 - slot) * TUPLE_W + (OUT_CHANNEL - 1 - i) * BITWIDTH +: BITWIDTH] = BITWIDTH'(q);
                end
                if (exp_sat > 65535) exp_sat = 65535;
                slot++;
                if (slot == PACK || idx == n - 1) begin
                    exp_addr_q.push_back(addr);
                    exp_data_q.push_back(word);
                    exp_cyc_q.push_back(cyc + 1);
                    addr = addr + ADDR_W'(1);
                    word = '0;
                    slot = 0;
                end
                idx++;
            end
            @(negedge clk);
            start = 1'b0;
        end
        if (idx < n) check("tile_accept_timeout", WORD_W'(idx), WORD_W'(n));
        in_valid = 1'b1; in_last = 1'b1;
        for (int k = 0; k < 2; k++) begin
            check("ready_low_after_last", WORD_W'(in_ready), WORD_W'(0));
            @(negedge clk);
        end
        in_valid = 1'b0; in_last = 1'b0;
        w = 0;
        while (done_cyc_q.size() == 0 && w < 10) begin
            @(negedge clk);
            w++;
        end
        repeat (2) @(negedge clk);
        check("wr_count", WORD_W'(wr_addr_q.size()), WORD_W'(exp_addr_q.size()));
        for (int i = 0; i < exp_addr_q.size() && i < wr_addr_q.size(); i++) begin
            check("wr_addr", WORD_W'(wr_addr_q[i]), WORD_W'(exp_addr_q[i]));
            check("wr_data", wr_data_q[i], exp_data_q[i]);
            check("wr_cycle", WORD_W'(wr_cyc_q[i]), WORD_W'(exp_cyc_q[i]));
        end
        check("done_count", WORD_W'(done_cyc_q.size()), WORD_W'(1));
        if (done_cyc_q.size() > 0 && exp_cyc_q.size() > 0)
            check("done_cycle", WORD_W'(done_cyc_q[0]), WORD_W'(exp_cyc_q[exp_cyc_q.size() - 1] + 1));
        check("sat_cnt", WORD_W'(sat_cnt), WORD_W'(exp_sat));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, WORD_W'(in_ready), WORD_W'(0));
        check({tag, "_sram_wen"}, WORD_W'(sram_wen), WORD_W'(0));
        check({tag, "_sram_addr"}, WORD_W'(sram_addr), WORD_W'(0));
        check({tag, "_sram_wdata"}, sram_wdata, WORD_W'(0));
        check({tag, "_done"}, WORD_W'(done), WORD_W'(0));
        check({tag, "_sat_cnt"}, WORD_W'(sat_cnt), WORD_W'(0));
    endtask

    logic [ADDR_W-1:0] rbase;

    initial begin
        srstn = 1'b0; start = 1'b0; base_addr = '0; out_shift = '0;
        in_valid = 1'b0; in_last = 1'b0; in_data = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs("por");
        srstn = 1'b1;

        // Directed rounding and saturation.
        tq.delete();
        tq.push_back(mk_tuple(40, -40, 8, 7));
        tq.push_back(mk_tuple(5000, -5000, 0, 0));
        run_tile(ADDR_W'(10'h005), 4, 0, 1'b0);
        check("dir_word", wr_data_q.size() > 0 ? wr_data_q[0] : WORD_W'(0),
              128'h03FE0100_7F800000_00000000_00000000);
        check("dir_sat_cnt", WORD_W'(sat_cnt), WORD_W'(2));

        // Two full words back-to-back, then the same tuples with bubbles.
        fill_random(8, 5);
        run_tile(ADDR_W'(10'h010), 5, 0, 1'b0);
        run_tile(ADDR_W'(10'h010), 5, 1, 1'b1);

        // Partial second word.
        fill_random(6, 3);
        run_tile(ADDR_W'(10'h020), 3, 0, 1'b0);

        // Address wrap.
        fill_random(8, 7);
        run_tile(ADDR_W'(10'h3FF), 7, 2, 1'b0);

        // Reset in the middle of a tile.
        clear_queues();
        fill_random(3, 2);
        @(negedge clk);
        start = 1'b1; base_addr = ADDR_W'(10'h100); out_shift = BW_FL'(2);
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_last = 1'b0; in_data = tq[i];
            @(negedge clk);
        end
        in_valid = 1'b0;
        srstn = 1'b0;
        @(negedge clk);
        check_reset_outputs("mid_rst");
        srstn = 1'b1;
        @(negedge clk);
        check_reset_outputs("post_rst");
        check("mid_rst_writes", WORD_W'(wr_addr_q.size()), WORD_W'(0));
        check("mid_rst_done", WORD_W'(done_cyc_q.size()), WORD_W'(0));

        // Zero shift, then random tiles.
        fill_random(11, 0);
        run_tile(ADDR_W'(10'h040), 0, 2, 1'b0);
        for (int t = 0; t < 6; t++) begin
            int s;
            s = (t == 5) ? 31 : int'($urandom_range(0, 12));
            rbase = ADDR_W'($urandom);
            fill_random(int'($urandom_range(1, 13)), s);
            run_tile(rbase, s, int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/relu_quant_pack.md
# relu_quant_pack

Output stage directly downstream of the directional ReLU in the zebranet accelerator. Accepts one ReLU tuple (OUT_CHANNEL signed BW_RELU values) per handshake, requantizes each channel to signed BITWIDTH by rounded arithmetic right shift and saturation, and packs PACK consecutive tuples into one output-SRAM write word. Writes go to sequential addresses from a per-tile base; the tile ends on the last input or after a flush.

## Interface
- BITWIDTH, 8, output activation width (`BITWIDTH)
- OUT_CHANNEL, 4, channels per tuple (`OUT_CHANNEL)
- GROUP_CHANNEL, 16, as in ReLU; sets BW_RELU
- BW_RELU, 2*BITWIDTH+4+$clog2(GROUP_CHANNEL)+10 (=34), input lane width
- BW_FL, 5, shift-amount width (`BW_FL)
- PACK, 4, tuples per SRAM word (power of 2)
- ADDR_W, 10, SRAM address width
- clk  in  1  clock, all logic on rising edge
- srstn  in  1  synchronous active-low reset
- start  in  1  pulse in IDLE: latch base_addr and out_shift, enter RUN
- base_addr  in  ADDR_W  first write address of tile
- out_shift  in  BW_FL  right-shift amount for requantization
- in_valid  in  1  relu_out tuple valid
- in_ready  out  1  block accepts tuple
- in_last  in  1  qualifies accepted tuple as last of tile
- in_data  in  OUT_CHANNEL*BW_RELU  {x0,x1,x2,x3}, x0 in MSBs, signed lanes
- sram_wen  out  1  write enable, active high, one cycle per word
- sram_addr  out  ADDR_W  write address
- sram_wdata  out  PACK*OUT_CHANNEL*BITWIDTH  packed word, tuple 0 in MSBs, same lane order within tuple
- done  out  1  one-cycle pulse after final word written
- sat_cnt  out  16  number of saturated lanes this tile, saturating counter

## Operation
- States: IDLE, RUN, FLUSH. IDLE -start-> RUN (latch base_addr, out_shift; clear pack count, sat_cnt). RUN: accept when in_valid && in_ready. Accepted tuple with in_last -> FLUSH. FLUSH: emit pending word (if any), pulse done, -> IDLE.
- in_ready = 1 only in RUN. start outside IDLE is ignored.
- Requantize per lane: s = out_shift; if s==0, r = x; else r = (x + 2^(s-1)) >>> s (round half up, computed at BW_RELU+1 bits, no overflow). Saturate r to [-2^(BITWIDTH-1), 2^(BITWIDTH-1)-1]; each clipped lane increments sat_cnt (stops at 0xFFFF).
- Packing: quantized tuple written into slot pack_cnt (0 = MSBs). When slot PACK-1 is filled, word is written at addr, addr increments by 1 (wraps modulo 2^ADDR_W), pack_cnt -> 0.
- Partial word at in_last: unfilled slots are zero; word written; done follows.
- in_last on slot PACK-1: single write, no extra empty word.
- in_last on the first tuple after start: one word with slots 1..PACK-1 zero.

## Timing
- Stage 1 (register): quantize+saturate on handshake cycle, registered into pack buffer.
- Write latency: sram_wen asserts the cycle after the handshake that completes a word (or carries in_last). sram_addr/sram_wdata valid in that cycle only; otherwise sram_wen=0 and wdata holds.
- done asserts the cycle after the final sram_wen; in_ready is 0 from the cycle after in_last acceptance until back in IDLE.
- Throughput 1 tuple/cycle in RUN, no bubbles at word boundaries.
- Reset values: in_ready=0, sram_wen=0, sram_addr=0, sram_wdata=0, done=0, sat_cnt=0, state IDLE, pack buffer cleared.
- srstn low mid-tile: pending partial word discarded, no write, no done.

## Structure
- Shared package/header: BITWIDTH, OUT_CHANNEL, BW_FL macros already global; add state encodings (IDLE/RUN/FLUSH) and BW_RELU derivation so ReLU and this block agree.
- One sub-module natural: requant_lane (combinational round/shift/saturate of one lane, with sat flag output), instantiated OUT_CHANNEL times.

## Test plan
- Round/sat: out_shift=4, lanes {40, -40, 8, 7} -> quantized {3, -2, 1, 0}; lane 5000 with shift 4 -> 127, sat_cnt=1; lane -5000 -> -128.
- Full words: base_addr=0x010, 8 back-to-back tuples, in_last on 8th -> writes at 0x010, 0x011, no third word, done 1 cycle after second write.
- Partial: 6 tuples, in_last on 6th -> second word at base+1 has slots 2,3 zero; done follows.
- Backpressure/bubbles: in_valid toggling 1,0,1,0 -> words identical to back-to-back case; in_valid during FLUSH not accepted.
- Wrap: base_addr=0x3FF, 8 tuples -> writes at 0x3FF then 0x000.
- Reset mid-tile: srstn low after 3 tuples -> no sram_wen, no done, all outputs at reset values; new start works normally.
